axi_lite_master: RTL and testbench

//  Single-outstanding AXI4-Lite master. It turns a simple command/response interface

---
 rtl/axi_lite_pkg.sv | 24 ++
 rtl/axi_lite_watchdog.sv | 53 +++++
 rtl/axi_lite_master.sv | 215 +++++++++++++++++++++
 tb/tb_axi_lite_master.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
//   Shared definitions for the AXI4-Lite master: response codes and the
//   master FSM state encoding.
// ---------------------------------------------------------------------------
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,   // waiting for a command
        WR   = 3'd1,   // AW and W channels in flight
        WR_B = 3'd2,   // waiting for the write response
        RD_A = 3'd3,   // AR channel in flight
        RD_D = 3'd4,   // waiting for read data
        RSP  = 3'd5    // presenting the response to the requester
    } state_t;

endpackage

// File: rtl/axi_lite_watchdog.sv
// ---------------------------------------------------------------------------
// axi_lite_watchdog
//   Cycle counter that flags a transaction as expired once it has been busy
//   for TIMEOUT_CYCLES cycles. TIMEOUT_CYCLES = 0 disables it entirely.
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset
//   clear    in   reload the counter with 0
//   enable   in   count this cycle (transaction in progress)
//   expired  out  enable is high and the counter has reached TIMEOUT_CYCLES-1
// ---------------------------------------------------------------------------
module axi_lite_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            assign expired = 1'b0;

            logic unused_inputs;
            assign unused_inputs = clk ^ rst_n ^ clear ^ enable;
        end else begin : g_enabled
            localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] count;

            // Saturates at LAST so that a phase handshake honoured in the
            // expiry cycle still leads to an abort in the following phase.
            // NOTE: state registers are updated with non-blocking assignments so
            // every always_ff reads the pre-edge value of every other register.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (enable && (count != LAST)) begin
                    count <= count + CW'(1);
                end
            end

            assign expired = enable && (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/axi_lite_master.sv
// ---------------------------------------------------------------------------
// axi_lite_master
//   Single-outstanding AXI4-Lite master. Converts a command/response
//   interface into AXI4-Lite write and read transactions, with a watchdog
//   that aborts transactions the slave never completes.
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESETN   clock / synchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_write, cmd_addr,
//   cmd_wdata, cmd_wstrb        command payload (1 = write)
//   rsp_valid/rsp_ready         response handshake (held until consumed)
//   rsp_rdata, rsp_resp,
//   rsp_timeout                 response payload (rdata 0 for writes/timeouts)
//   bus_hung                    sticky timeout flag, cleared only by reset
//   M_AXI_AW*/W*/B*/AR*/R*      AXI4-Lite master channels
// ---------------------------------------------------------------------------
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic                            bus_hung,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,

    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    state_t state;

    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    assign M_AXI_AWPROT = PROT_DEFAULT;
    assign M_AXI_ARPROT = PROT_DEFAULT;

    assign wd_clear  = (state == IDLE);
    assign wd_enable = (state == WR) || (state == WR_B) || (state == RD_A) || (state == RD_D);

    axi_lite_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (M_AXI_ACLK),
        .rst_n   (M_AXI_ARESETN),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // A channel is still open after this edge if it is valid and not accepted.
    logic aw_open;
    logic w_open;
    logic completing;
    logic abort;

    assign aw_open = M_AXI_AWVALID && !M_AXI_AWREADY;
    assign w_open  = M_AXI_WVALID  && !M_AXI_WREADY;

    // The current phase finishes this cycle; this wins over an expiring watchdog.
    assign completing = ((state == WR)   && !aw_open && !w_open) ||
                        ((state == WR_B) && M_AXI_BVALID)        ||
                        ((state == RD_A) && M_AXI_ARREADY)       ||
                        ((state == RD_D) && M_AXI_RVALID);

    assign abort = wd_expired && !completing;

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state         <= IDLE;
            cmd_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= RESP_OKAY;
            rsp_timeout   <= 1'b0;
            bus_hung      <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else if (abort) begin
            // Watchdog abort: withdraw from every channel and report SLVERR.
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_rdata     <= '0;
            rsp_resp      <= RESP_SLVERR;
            rsp_timeout   <= 1'b1;
            bus_hung      <= 1'b1;
            state         <= RSP;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            M_AXI_AWADDR  <= cmd_addr;
                            M_AXI_WDATA   <= cmd_wdata;
                            M_AXI_WSTRB   <= cmd_wstrb;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= WR;
                        end else begin
                            M_AXI_ARADDR  <= cmd_addr;
                            M_AXI_ARVALID <= 1'b1;
                            state         <= RD_A;
                        end
                    end
                end

                WR: begin
                    if (M_AXI_AWREADY) begin
                        M_AXI_AWVALID <= 1'b0;
                    end
                    if (M_AXI_WREADY) begin
                        M_AXI_WVALID <= 1'b0;
                    end
                    if (!aw_open && !w_open) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= WR_B;
                    end
                end

                WR_B: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= '0;
                        rsp_resp     <= M_AXI_BRESP;
                        rsp_timeout  <= 1'b0;
                        state        <= RSP;
                    end
                end

                RD_A: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RD_D;
                    end
                end

                RD_D: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= M_AXI_RDATA;
                        rsp_resp     <= M_AXI_RRESP;
                        rsp_timeout  <= 1'b0;
                        state        <= RSP;
                    end
                end

                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_master
//   Self-checking bench: a configurable AXI4-Lite slave model, a response
//   consumer that compares every response against a scoreboard queue, and a
//   directed sequence of transactions. A slave "delay d" means the READY or
//   VALID rises d cycles after it becomes due, so a VALID waiting on a
//   READY delayed by d stays high for d+1 cycles.
// ---------------------------------------------------------------------------
module tb_axi_lite_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    typedef struct {
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
        logic          timeout;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_timeout;
    logic          bus_hung;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    axi_lite_master #(
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES     (TO)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .bus_hung      (bus_hung),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- slave model configuration ----------------
    int          aw_delay = 0;
    int          w_delay  = 0;
    int          b_delay  = 0;
    int          ar_delay = 0;
    int          r_delay  = 0;
    bit          ar_never = 1'b0;
    logic [1:0]  s_bresp  = 2'b00;
    logic [1:0]  s_rresp  = 2'b00;
    logic [DW-1:0] s_rdata = '0;

    int cyc   = 0;
    bit aw_got = 1'b0;
    bit w_got  = 1'b0;
    bit b_pend = 1'b0;
    bit r_pend = 1'b0;
    int b_hs   = 0;

    // Handshake tracking on the active edge (reads only; drives nothing).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            b_pend <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            if (awvalid && awready) aw_got <= 1'b1;
            if (wvalid && wready)   w_got  <= 1'b1;
            if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) && !b_pend)
                b_pend <= 1'b1;
            if (bvalid && bready) begin
                b_hs   <= b_hs + 1;
                b_pend <= 1'b0;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (arvalid && arready) r_pend <= 1'b1;
            if (rvalid && rready)   r_pend <= 1'b0;
        end
    end

    // Slave drive on the falling edge.
    int aw_cnt = 0;
    int w_cnt  = 0;
    int b_cnt  = 0;
    int ar_cnt = 0;
    int r_cnt  = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
            bresp = 2'b00; rresp = 2'b00; rdata = '0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        end else begin
            if (awvalid) begin awready = (aw_cnt >= aw_delay); aw_cnt++; end
            else begin awready = 1'b0; aw_cnt = 0; end
            if (wvalid) begin wready = (w_cnt >= w_delay); w_cnt++; end
            else begin wready = 1'b0; w_cnt = 0; end
            if (arvalid && !ar_never) begin arready = (ar_cnt >= ar_delay); ar_cnt++; end
            else begin arready = 1'b0; ar_cnt = 0; end
            if (b_pend) begin bvalid = (b_cnt >= b_delay); bresp = s_bresp; b_cnt++; end
            else begin bvalid = 1'b0; b_cnt = 0; end
            if (r_pend) begin rvalid = (r_cnt >= r_delay); rdata = s_rdata; rresp = s_rresp; r_cnt++; end
            else begin rvalid = 1'b0; r_cnt = 0; end
        end
    end

    // ---------------- response consumer + scoreboard ----------------
    exp_t exp_q[$];
    int   rsp_hold      = 0;
    int   hold_cnt      = 0;
    bit   rsp_seen      = 1'b0;
    int   first_rsp_cyc = 0;
    int   rsp_cnt       = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rsp_ready = 1'b1;
            hold_cnt  = 0;
            rsp_seen  = 1'b0;
        end else if (rsp_valid) begin
            if (!rsp_seen) begin
                rsp_seen      = 1'b1;
                first_rsp_cyc = cyc;
            end
            check("cmd_ready_during_rsp", cmd_ready, 1'b0);
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", exp_q.size(), 1);
            end else begin
                check("rsp_rdata",   rsp_rdata,   exp_q[0].rdata);
                check("rsp_resp",    rsp_resp,    exp_q[0].resp);
                check("rsp_timeout", rsp_timeout, exp_q[0].timeout);
            end
            if (hold_cnt < rsp_hold) begin
                rsp_ready = 1'b0;
                hold_cnt++;
            end else begin
                rsp_ready = 1'b1;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                hold_cnt = 0;
                rsp_seen = 1'b0;
                rsp_cnt++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int t_acc    = 0;
    int aw_hi    = 0;
    int w_hi     = 0;
    int ar_hi    = 0;
    int unstable = 0;

    task automatic push_exp(input logic [DW-1:0] d, input logic [1:0] r, input logic t);
        exp_t e;
        e.rdata = d; e.resp = r; e.timeout = t;
        exp_q.push_back(e);
    endtask

    // Presents a command at a falling edge; returns at the falling edge of the
    // cycle after acceptance (t_acc = that cycle's number).
    task automatic send_cmd(input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [3:0] s);
        int n;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("cmd_accept", cmd_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        t_acc = cyc;
    endtask

    // Watches the AXI channels until rsp_cnt reaches target, recording how
    // long each VALID stays high and whether address/data ever move.
    task automatic watch_until(input int target, input int budget,
                               input logic [AW-1:0] ea, input logic [DW-1:0] ed);
        aw_hi = 0; w_hi = 0; ar_hi = 0; unstable = 0;
        for (int n = 0; n < budget; n++) begin
            if (awvalid) begin aw_hi++; if (awaddr !== ea) unstable++; end
            if (wvalid)  begin w_hi++;  if (wdata  !== ed) unstable++; end
            if (arvalid) begin ar_hi++; if (araddr !== ea) unstable++; end
            if (rsp_cnt >= target) break;
            @(negedge clk);
        end
        if (rsp_cnt < target) check("rsp_within_budget", rsp_cnt, target);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int b0;
        int target;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_cmd_ready",   cmd_ready,   1'b1);
        check("rst_awvalid",     awvalid,     1'b0);
        check("rst_wvalid",      wvalid,      1'b0);
        check("rst_bready",      bready,      1'b0);
        check("rst_arvalid",     arvalid,     1'b0);
        check("rst_rready",      rready,      1'b0);
        check("rst_rsp_valid",   rsp_valid,   1'b0);
        check("rst_rsp_timeout", rsp_timeout, 1'b0);
        check("rst_bus_hung",    bus_hung,    1'b0);
        check("prot_aw",         awprot,      3'b000);
        check("prot_ar",         arprot,      3'b000);

        rst_n = 1'b1;
        @(negedge clk);
        target = 0;

        // 1. zero-wait write
        push_exp('0, 2'b00, 1'b0);
        send_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        check("w0_awvalid_n1",  awvalid,   1'b1);
        check("w0_wvalid_n1",   wvalid,    1'b1);
        check("w0_cmd_ready_n1", cmd_ready, 1'b0);
        check("w0_wstrb",       wstrb,     4'hF);
        target++;
        watch_until(target, 40, 32'h10, 32'hDEADBEEF);
        check("w0_aw_cycles",   aw_hi,         1);
        check("w0_w_cycles",    w_hi,          1);
        check("w0_rsp_latency", first_rsp_cyc, t_acc + 2);
        check("w0_stable",      unstable,      0);
        check("w0_cmd_ready_after", cmd_ready, 1'b1);

        // 1b. zero-wait read
        s_rdata = 32'hA5A5_0001;
        push_exp(32'hA5A5_0001, 2'b00, 1'b0);
        send_cmd(1'b0, 32'h20, '0, 4'h0);
        target++;
        watch_until(target, 40, 32'h20, '0);
        check("r0_ar_cycles",   ar_hi,         1);
        check("r0_rsp_latency", first_rsp_cyc, t_acc + 2);

        // 2. delayed AWREADY (3) and WREADY (1)
        aw_delay = 3; w_delay = 1;
        b0 = b_hs;
        push_exp('0, 2'b00, 1'b0);
        send_cmd(1'b1, 32'h0000_0044, 32'hCAFE_F00D, 4'h3);
        target++;
        watch_until(target, 40, 32'h0000_0044, 32'hCAFE_F00D);
        check("w1_aw_cycles", aw_hi,     4);
        check("w1_w_cycles",  w_hi,      2);
        check("w1_stable",    unstable,  0);
        check("w1_b_count",   b_hs - b0, 1);
        aw_delay = 0; w_delay = 0;

        // 3. read with RVALID delayed 5 and rsp_ready held low 4 cycles
        s_rdata = 32'h12345678; r_delay = 5; rsp_hold = 4;
        push_exp(32'h12345678, 2'b00, 1'b0);
        send_cmd(1'b0, 32'h04, '0, 4'h0);
        target++;
        watch_until(target, 60, 32'h04, '0);
        check("r1_rsp_latency", first_rsp_cyc, t_acc + 7);
        check("r1_cmd_ready_after", cmd_ready, 1'b1);
        r_delay = 0; rsp_hold = 0;

        // 4. write answered with SLVERR
        s_bresp = 2'b10;
        push_exp('0, 2'b10, 1'b0);
        send_cmd(1'b1, 32'h08, 32'h0000_0001, 4'h1);
        target++;
        watch_until(target, 40, 32'h08, 32'h0000_0001);
        check("w2_bus_hung", bus_hung, 1'b0);
        s_bresp = 2'b00;

        // 5. ARREADY never arrives -> watchdog abort, then recovery
        ar_never = 1'b1;
        push_exp('0, 2'b10, 1'b1);
        send_cmd(1'b0, 32'h30, '0, 4'h0);
        target++;
        watch_until(target, 60, 32'h30, '0);
        check("to_ar_cycles",   ar_hi,         TO);
        check("to_rsp_latency", first_rsp_cyc, t_acc + TO);
        check("to_bus_hung",    bus_hung,      1'b1);
        check("to_rready",      rready,        1'b0);
        ar_never = 1'b0;
        s_rdata = 32'h0BAD_CAFE;
        push_exp(32'h0BAD_CAFE, 2'b00, 1'b0);
        send_cmd(1'b0, 32'h34, '0, 4'h0);
        target++;
        watch_until(target, 40, 32'h34, '0);
        check("to_recover_bus_hung", bus_hung, 1'b1);

        // 6. reset while waiting in WR_B
        b_delay = 10;
        push_exp('0, 2'b00, 1'b0);
        send_cmd(1'b1, 32'h50, 32'h5555_AAAA, 4'hF);
        for (int n = 0; n < 20 && !bready; n++) @(negedge clk);
        check("rst_mid_bready_seen", bready, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_bready",    bready,    1'b0);
        check("rst_mid_rsp_valid", rsp_valid, 1'b0);
        check("rst_mid_cmd_ready", cmd_ready, 1'b1);
        check("rst_mid_bus_hung",  bus_hung,  1'b0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        b_delay = 0;
        @(negedge clk);

        s_rdata = 32'h7777_0006;
        push_exp(32'h7777_0006, 2'b00, 1'b0);
        send_cmd(1'b0, 32'h60, '0, 4'h0);
        target++;
        watch_until(target, 40, 32'h60, '0);
        check("post_rst_rsp_latency", first_rsp_cyc, t_acc + 2);
        check("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
